// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result and flags.
// Ops 0-6 finish one cycle after accept. MUL is a shift-add unit that
// handles one multiplier bit per cycle, LSB first.
// The result is held in DONE until the consumer takes it. A new beat may
// launch in the same cycle the old result retires.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zero_x,
  input  logic             zero_y,
  input  logic             negate_output,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             is_zero,
  output logic             is_negative,
  output logic             carry,
  output logic             overflow
);

  localparam logic [2:0] OP_OR  = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               zero_reg;
  logic               neg_reg;
  logic               carry_reg;
  logic               ovf_reg;

  // Multiplier datapath: the multiplicand is pre-widened so that it can
  // shift left without losing the bits that form the high half.
  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               mneg_reg;

  logic               accept;
  logic [WIDTH-1:0]   x_eff;
  logic [WIDTH-1:0]   y_eff;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH-1:0]   sub_val;
  logic [CNT_W-2:0]   shamt;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [WIDTH-1:0]   alu_raw;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;

  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_hi;

  assign in_ready = (state_reg == ST_IDLE) | ((state_reg == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign out_valid   = (state_reg == ST_DONE);
  assign result      = result_reg;
  assign is_zero     = zero_reg;
  assign is_negative = neg_reg;
  assign carry       = carry_reg;
  assign overflow    = ovf_reg;

  assign x_eff = zero_x ? '0 : x;
  assign y_eff = zero_y ? '0 : y;

  // The extra bit on each shift catches the last bit shifted out.
  // When the shift amount is zero, that bit is 0.
  assign add_ext = {1'b0, x_eff} + {1'b0, y_eff};
  assign sub_val = x_eff - y_eff;
  assign shamt   = y_eff[CNT_W-2:0];
  assign shl_ext = {1'b0, x_eff} << shamt;
  assign shr_ext = {x_eff, 1'b0} >> shamt;

  // Single-cycle ops: raw value plus carry and overflow, both taken from the raw value.
  always_comb begin
    alu_raw   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (opcode)
      OP_OR:  alu_raw = x_eff | y_eff;
      OP_AND: alu_raw = x_eff & y_eff;
      OP_XOR: alu_raw = x_eff ^ y_eff;
      OP_ADD: begin
        alu_raw   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = (x_eff[WIDTH-1] == y_eff[WIDTH-1]) &&
                    (add_ext[WIDTH-1] != x_eff[WIDTH-1]);
      end
      OP_SUB: begin
        alu_raw   = sub_val;
        alu_carry = (x_eff < y_eff);
        alu_ovf   = (x_eff[WIDTH-1] != y_eff[WIDTH-1]) &&
                    (sub_val[WIDTH-1] != x_eff[WIDTH-1]);
      end
      OP_SHL: begin
        alu_raw   = shl_ext[WIDTH-1:0];
        alu_carry = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_raw   = shr_ext[WIDTH:1];
        alu_carry = shr_ext[0];
      end
      default: begin
        alu_raw   = '0;
        alu_carry = 1'b0;
      end
    endcase
    alu_res = negate_output ? ~alu_raw : alu_raw;
  end

  // Next accumulator value for this multiply step.
  // On the final step it is also the full product.
  always_comb begin
    mul_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    mul_res = mneg_reg ? ~mul_sum[WIDTH-1:0] : mul_sum[WIDTH-1:0];
    mul_hi  = |mul_sum[2*WIDTH-1:WIDTH];
  end

  // Control FSM, result/flag registers and multiplier iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      carry_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      mneg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              mcand_reg  <= {{WIDTH{1'b0}}, x_eff};
              mplier_reg <= y_eff;
              acc_reg    <= '0;
              count_reg  <= CNT_INIT;
              mneg_reg   <= negate_output;
              state_reg  <= ST_MUL;
            end else begin
              result_reg <= alu_res;
              zero_reg   <= (alu_res == '0);
              neg_reg    <= alu_res[WIDTH-1];
              carry_reg  <= alu_carry;
              ovf_reg    <= alu_ovf;
              state_reg  <= ST_DONE;
            end
          end else if ((state_reg == ST_DONE) && out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_MUL: begin
          acc_reg    <= mul_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg - CNT_ONE;
          if (count_reg == CNT_ONE) begin
            result_reg <= mul_res;
            zero_reg   <= (mul_res == '0);
            neg_reg    <= mul_res[WIDTH-1];
            carry_reg  <= mul_hi;
            ovf_reg    <= 1'b0;
            state_reg  <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=16).
// An arithmetic reference model queues the expected result for every
// accepted beat. A monitor checks each retired result against that queue
// and checks that the outputs stay stable while stalled.
// Directed scenarios pin latency, backpressure and reset behaviour.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         zero_x = 1'b0;
  logic         zero_y = 1'b0;
  logic         negate_output = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         is_zero;
  logic         is_negative;
  logic         carry;
  logic         overflow;

  logic rand_ready  = 1'b0;
  logic ready_force = 1'b0;
  logic rnd_ready   = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   retire_cnt = 0;

  typedef logic [W+3:0] exp_t;
  exp_t exp_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zero_x(zero_x), .zero_y(zero_y),
    .negate_output(negate_output), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .is_zero(is_zero), .is_negative(is_negative),
    .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign out_ready = rand_ready ? rnd_ready : ready_force;

  // Free-running cycle counter and random consumer readiness.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rnd_ready <= ($urandom_range(0, 3) != 0);
  end

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] xi,
                                 input logic [W-1:0] yi, input logic zx,
                                 input logic zy, input logic ng);
    logic [W-1:0]   xe, ye, raw, res;
    logic [2*W-1:0] p;
    logic           c, v;
    int             amt;
    xe  = zx ? '0 : xi;
    ye  = zy ? '0 : yi;
    amt = int'(ye % 16);
    c   = 1'b0;
    v   = 1'b0;
    p   = '0;
    case (op)
      3'd0: raw = xe | ye;
      3'd1: raw = xe & ye;
      3'd4: raw = xe ^ ye;
      3'd2: begin
        p   = xe + ye;
        raw = p[W-1:0];
        c   = p[W];
        v   = (xe[W-1] == ye[W-1]) && (raw[W-1] != xe[W-1]);
      end
      3'd3: begin
        raw = xe - ye;
        c   = (xe < ye);
        v   = (xe[W-1] != ye[W-1]) && (raw[W-1] != xe[W-1]);
      end
      3'd5: begin
        p   = {16'h0000, xe} << amt;
        raw = p[W-1:0];
        c   = (amt != 0) && p[W];
      end
      3'd6: begin
        raw = xe >> amt;
        c   = (amt != 0) ? xe[amt-1] : 1'b0;
      end
      default: begin
        p   = xe * ye;
        raw = p[W-1:0];
        c   = |p[2*W-1:W];
      end
    endcase
    res = ng ? ~raw : raw;
    return {res, (res == '0), res[W-1], c, v};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: stall stability, retire checks against the model queue, and
  // capture of accepted beats into that queue.
  initial begin
    logic          hold_v;
    logic [W+3:0]  hold_val;
    logic [W+3:0]  got;
    exp_t          e;
    hold_v   = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      got = {result, is_zero, is_negative, carry, overflow};
      if (rst) begin
        exp_q.delete();
        hold_v = 1'b0;
      end else begin
        if (hold_v) check("hold_stable", {out_valid, got}, {1'b1, hold_val});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("retire_without_beat", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            retire_cnt++;
            $display("retire %0d: result=0x%04h z=%0d n=%0d c=%0d v=%0d",
                     retire_cnt, result, is_zero, is_negative, carry, overflow);
            check("retire_value", got, e);
          end
        end
        hold_v   = out_valid && !out_ready;
        hold_val = got;
        if (in_valid && in_ready)
          exp_q.push_back(model(opcode, x, y, zero_x, zero_y, negate_output));
      end
    end
  end

  // Presents one beat and returns one cycle after it was accepted
  // (i.e., #1 after the accept edge).
  task automatic send(input logic [2:0] op, input logic [W-1:0] xa, input logic [W-1:0] ya,
                      input logic zx, input logic zy, input logic ng);
    logic got_it;
    got_it        = 1'b0;
    in_valid      = 1'b1;
    opcode        = op;
    x             = xa;
    y             = ya;
    zero_x        = zx;
    zero_y        = zy;
    negate_output = ng;
    for (int i = 0; i < 200 && !got_it; i++) begin
      @(negedge clk);
      got_it = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept_within_bound", got_it, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, rc0, bad;
    logic [2:0] op;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, result, is_zero, is_negative, carry, overflow}, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;
    step();

    // Pin the reference model with hand-computed values.
    check("model_add", model(3'd2, 16'h7FFF, 16'h0001, 0, 0, 0), {16'h8000, 4'b0101});
    check("model_sub_neg", model(3'd3, 16'h0000, 16'h0001, 0, 0, 1), {16'h0000, 4'b1010});
    check("model_shr", model(3'd6, 16'h0003, 16'h0001, 0, 0, 0), {16'h0001, 4'b0010});
    check("model_mul", model(3'd7, 16'h0003, 16'h0005, 0, 0, 0), {16'h000F, 4'b0000});
    check("model_zero_x", model(3'd2, 16'h1234, 16'h0001, 1, 0, 0), {16'h0001, 4'b0000});

    // 1) Reset in the middle of a multiply.
    ready_force = 1'b1;
    send(3'd7, 16'd3, 16'd5, 0, 0, 0);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midmul_rst_out_valid", out_valid, 0);
    check("midmul_rst_result", result, 0);
    check("midmul_rst_in_ready", in_ready, 1);
    step();

    // 2) ADD with signed overflow, 1-cycle latency.
    ready_force = 1'b0;
    send(3'd2, 16'h7FFF, 16'h0001, 0, 0, 0);
    check("add_out_valid", out_valid, 1);
    check("add_value", {result, is_zero, is_negative, carry, overflow}, {16'h8000, 4'b0101});
    ready_force = 1'b1;
    step();

    // 3) SUB borrow, then the same with negation.
    send(3'd3, 16'h0000, 16'h0001, 0, 0, 0);
    check("sub_value", {result, is_zero, is_negative, carry, overflow}, {16'hFFFF, 4'b0110});
    send(3'd3, 16'h0000, 16'h0001, 0, 0, 1);
    check("sub_neg_value", {result, is_zero, is_negative, carry, overflow}, {16'h0000, 4'b1010});
    step();

    // 4) MUL with non-zero high half; result valid exactly 16 cycles after accept.
    ready_force = 1'b0;
    send(3'd7, 16'h0100, 16'h0100, 0, 0, 0);
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      if (out_valid || in_ready) bad++;
      step();
    end
    check("mul_busy_cycles", bad, 0);
    check("mul_out_valid_at_16", out_valid, 1);
    check("mul_value", {result, is_zero, is_negative, carry, overflow}, {16'h0000, 4'b1010});
    ready_force = 1'b1;
    step();

    // 5) Back-to-back beats with no bubble.
    c0  = cyc;
    bad = 0;
    send(3'd0, 16'h00F0, 16'h0F00, 0, 0, 0);
    if (!out_valid) bad++;
    send(3'd1, 16'h00F0, 16'h0FF0, 0, 0, 0);
    if (!out_valid) bad++;
    send(3'd4, 16'h00FF, 16'h0FF0, 0, 0, 0);
    if (!out_valid) bad++;
    send(3'd5, 16'h8001, 16'h0001, 0, 0, 0);
    if (!out_valid) bad++;
    check("b2b_valid_each_cycle", bad, 0);
    check("b2b_cycles", cyc - c0, 4);
    check("shl_value", {result, is_zero, is_negative, carry, overflow}, {16'h0002, 4'b0010});
    step();

    // 6) Backpressure: hold for 5 cycles, then exactly one retire.
    ready_force = 1'b0;
    send(3'd2, 16'd2, 16'd3, 0, 0, 0);
    rc0 = retire_cnt;
    bad = 0;
    for (int j = 0; j < 5; j++) begin
      if (!out_valid || in_ready || result != 16'h0005) bad++;
      step();
    end
    check("stall_hold", bad, 0);
    ready_force = 1'b1;
    step();
    check("stall_release_drop", out_valid, 0);
    check("stall_single_retire", retire_cnt - rc0, 1);

    // Randomized beats with random consumer backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      send(op, pick(), pick(), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      x = W'($urandom);
      y = W'($urandom);
      opcode = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) step();
    end

    // Drain: every accepted beat must have retired.
    rand_ready  = 1'b0;
    ready_force = 1'b1;
    repeat (40) step();
    check("drain_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1);
  end

endmodule
